// File: rtl/alu_wb_stage_pkg.sv
// Shared cpu_2432 definitions for the writeback stage: FSM state encodings,
// flag-vector bit positions and default datapath/register-file widths.
package alu_wb_stage_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 4;

  typedef enum logic {
    RUN      = 1'b0,
    MCP_HOLD = 1'b1
  } wb_state_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;
  localparam int NFLAGS = 4;

  // Assemble the packed flag vector using the shared bit positions.
  function automatic logic [NFLAGS-1:0] pack_flags(input logic c, input logic v,
                                                   input logic z, input logic n);
    logic [NFLAGS-1:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/alu_wb_stage_flag_reg.sv
// flag_reg: 4-bit flag register with async active-low reset and load enable.
// Kept standalone so interrupt save/restore logic can reuse it.
module flag_reg
  import alu_wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset_b,
  input  logic              load,
  input  logic [NFLAGS-1:0] d,
  output logic [NFLAGS-1:0] q
);

  logic [NFLAGS-1:0] flags_q;

  // Flags load on enable, otherwise hold.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      flags_q <= '0;
    end else if (load) begin
      flags_q <= d;
    end
  end

  assign q = flags_q;

endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: execute-to-writeback register stage. Captures the ALU result
// into the register-file write port, commits C/V/Z/N and exposes a forwarding
// tap. Define MUL32_STALL_EN to enable the multi-cycle-path stall for 32x32
// MUL; without it ex_mcp is ignored and ex_ready is tied high.
module alu_wb_stage
  import alu_wb_stage_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int RW         = RW_DEF,
  parameter int MCP_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [DW-1:0] ex_dout,
  input  logic          ex_cout,
  input  logic          ex_vout,
  input  logic          ex_qnz,
  input  logic          ex_mcp,
  input  logic          ex_wen,
  input  logic [RW-1:0] ex_rdest,
  input  logic          ex_setf,
  input  logic          flush,
  output logic          rf_we,
  output logic [RW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          flag_c,
  output logic          flag_v,
  output logic          flag_z,
  output logic          flag_n,
  output logic          fwd_valid,
  output logic [RW-1:0] fwd_addr,
  output logic [DW-1:0] fwd_data
);

  logic capture;

`ifdef MUL32_STALL_EN
  // The RUN cycle that sees the request already counts as the first stall
  // cycle, so the hold counter starts one short of MCP_CYCLES. This gives
  // MCP_CYCLES cycles of ex_ready=0 and capture on edge 1+MCP_CYCLES.
  localparam logic [1:0] CNT_LOAD = 2'(MCP_CYCLES - 1);

  wb_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ready;

  // State and hold-counter registers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, hold countdown, ready and capture decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b1;
    capture = 1'b0;
    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = RUN;
        end else if (ex_valid && ex_mcp) begin
          ready   = 1'b0;
          state_d = MCP_HOLD;
          cnt_d   = CNT_LOAD;
        end else begin
          capture = ex_valid;
        end
      end
      MCP_HOLD: begin
        ready = (cnt_q == 2'd0);
        if (flush) begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end else if (cnt_q != 2'd0) begin
          cnt_d = 2'(cnt_q - 2'd1);
        end else if (ex_valid) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  assign ex_ready = ready;
`else
  localparam int unused_mcp_cycles = MCP_CYCLES;
  logic unused_mcp;

  assign unused_mcp = ex_mcp;
  assign ex_ready   = 1'b1;
  assign capture    = ex_valid & ~flush;
`endif

  logic          rf_we_q, rf_we_d;
  logic [RW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;

  // Write-port next values: enable pulses only on capture, address/data hold.
  always_comb begin
    rf_we_d    = capture & ex_wen;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (capture) begin
      rf_waddr_d = ex_rdest;
      rf_wdata_d = ex_dout;
    end
  end

  // Write-port registers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  logic [NFLAGS-1:0] flags_d, flags_q;
  logic              flags_load;

  assign flags_load = capture & ex_setf;
  assign flags_d    = pack_flags(ex_cout, ex_vout, ~ex_qnz, ex_dout[DW-1]);

  flag_reg u_flag_reg (
    .clk     (clk),
    .reset_b (reset_b),
    .load    (flags_load),
    .d       (flags_d),
    .q       (flags_q)
  );

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign fwd_valid = rf_we_q;
  assign fwd_addr  = rf_waddr_q;
  assign fwd_data  = rf_wdata_q;
  assign flag_c    = flags_q[FLAG_C];
  assign flag_v    = flags_q[FLAG_V];
  assign flag_z    = flags_q[FLAG_Z];
  assign flag_n    = flags_q[FLAG_N];

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage; expected writeback state per step is
// queued when stimulus is applied and compared after the clock edge.
module tb_alu_wb_stage;

`ifdef MUL32_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic        clk;
  logic        reset_b;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_dout;
  logic        ex_cout, ex_vout, ex_qnz, ex_mcp, ex_wen, ex_setf, flush;
  logic [3:0]  ex_rdest;
  logic        rf_we, fwd_valid;
  logic [3:0]  rf_waddr, fwd_addr;
  logic [31:0] rf_wdata, fwd_data;
  logic        flag_c, flag_v, flag_z, flag_n;

  alu_wb_stage dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_dout  (ex_dout),
    .ex_cout  (ex_cout),
    .ex_vout  (ex_vout),
    .ex_qnz   (ex_qnz),
    .ex_mcp   (ex_mcp),
    .ex_wen   (ex_wen),
    .ex_rdest (ex_rdest),
    .ex_setf  (ex_setf),
    .flush    (flush),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .flag_c   (flag_c),
    .flag_v   (flag_v),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .fwd_valid(fwd_valid),
    .fwd_addr (fwd_addr),
    .fwd_data (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  flags;   // {N,Z,V,C}
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_flags;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, ":rf_we"},     32'(rf_we), 32'(e.we));
    chk({tag, ":rf_waddr"},  32'(rf_waddr), 32'(e.addr));
    chk({tag, ":rf_wdata"},  rf_wdata, e.data);
    chk({tag, ":flags"},     32'({flag_n, flag_z, flag_v, flag_c}), 32'(e.flags));
    chk({tag, ":fwd_valid"}, 32'(fwd_valid), 32'(e.we));
    chk({tag, ":fwd_addr"},  32'(fwd_addr), 32'(e.addr));
    chk({tag, ":fwd_data"},  fwd_data, e.data);
  endtask

  // One clock of stimulus; called at posedge+1.
  task automatic step(input logic v, input logic mcp, input logic wen,
                      input logic [3:0] rd, input logic [31:0] d,
                      input logic c, input logic vo, input logic nz,
                      input logic sf, input logic fl,
                      input logic exp_cap, input logic exp_rdy, input string tag);
    exp_t e;
    ex_valid = v;  ex_mcp = mcp;  ex_wen = wen;  ex_rdest = rd;  ex_dout = d;
    ex_cout = c;   ex_vout = vo;  ex_qnz = nz;   ex_setf = sf;   flush = fl;
    #1;
    chk({tag, ":ex_ready"}, 32'(ex_ready), 32'(exp_rdy));
    e.we = exp_cap & wen;
    if (exp_cap) begin
      m_addr = rd;
      m_data = d;
      if (sf) m_flags = {d[31], ~nz, vo, c};
    end
    e.addr  = m_addr;
    e.data  = m_data;
    e.flags = m_flags;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk_outputs(tag, e);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 4'd0, 32'd0, 0, 0, 0, 0, 0, 1'b0, 1'b1, tag);
  endtask

  task automatic model_reset();
    m_addr  = '0;
    m_data  = '0;
    m_flags = '0;
  endtask

  initial begin
    exp_t zero;
    zero.we = 1'b0; zero.addr = '0; zero.data = '0; zero.flags = '0;
    model_reset();
    reset_b = 1'b0;
    ex_valid = 0; ex_mcp = 0; ex_wen = 0; ex_rdest = '0; ex_dout = '0;
    ex_cout = 0; ex_vout = 0; ex_qnz = 0; ex_setf = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset", zero);
    reset_b = 1'b1;

    // First op after reset
    step(1, 0, 1, 4'd3, 32'h0000_1234, 0, 0, 1, 0, 0, 1'b1, 1'b1, "first_op");

    // Flag commit then flag hold
    step(1, 0, 1, 4'd5, 32'h0000_0000, 1, 0, 0, 1, 0, 1'b1, 1'b1, "add_flags");
    step(1, 0, 1, 4'd6, 32'h8000_0000, 0, 1, 1, 0, 0, 1'b1, 1'b1, "noflag_op");
    idle("idle1");

    // Multi-cycle op
    step(1, 1, 1, 4'd7, 32'hFFFF_0001, 0, 0, 1, 0, 0, !STALL, !STALL, "mcp_c1");
    step(STALL, 1, 1, 4'd7, 32'hFFFF_0001, 0, 0, 1, 0, 0, STALL, 1'b1, "mcp_c2");
    idle("mcp_after");

    // Flush during the hold cycle
    step(1, 1, 1, 4'd8, 32'h0BAD_0000, 1, 1, 1, 1, 0, !STALL, !STALL, "fl_c1");
    step(1, 1, 1, 4'd8, 32'h0BAD_0000, 1, 1, 1, 1, 1, 1'b0, 1'b1, "fl_c2");
    step(1, 0, 1, 4'd9, 32'h0000_0099, 0, 0, 1, 1, 0, 1'b1, 1'b1, "after_flush");

    // Back-to-back captures
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 1, 4'(i), 32'(i * 32'h0101_0101), 1'(i), 0, 1, 1'(i >> 1), 0,
           1'b1, 1'b1, $sformatf("b2b%0d", i));
    end

    // Compare: flags update without a register write
    step(1, 0, 0, 4'd12, 32'h7FFF_FFFF, 0, 1, 1, 1, 0, 1'b1, 1'b1, "cmp");
    idle("idle2");

    // Reset asserted in the middle of a held multi-cycle op
    ex_valid = 1; ex_mcp = 1; ex_wen = 1; ex_rdest = 4'd10; ex_dout = 32'hDEAD_BEEF;
    ex_setf = 1; ex_cout = 1; ex_vout = 1; ex_qnz = 1; flush = 0;
    @(posedge clk);
    #2;
    reset_b = 1'b0;
    #1;
    model_reset();
    chk_outputs("mid_reset", zero);
    @(posedge clk);
    #1;
    chk_outputs("in_reset", zero);
    ex_valid = 0; ex_mcp = 0;
    reset_b = 1'b1;
    idle("post_reset_idle");
    step(1, 0, 1, 4'd3, 32'h0000_1234, 0, 0, 1, 0, 0, 1'b1, 1'b1, "post_reset_op");
    idle("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
